// File: rtl/exc_flush_ctrl.sv
// Exception/ERTN redirect sequencer: latches the target on acceptance, pulses a global flush, then holds the redirect until fetch takes it.
// Latency: flush one cycle after acceptance, redirect from the cycle after; while busy, new events are dropped and interrupt injection is masked.
module exc_flush_ctrl #(
  parameter logic [5:0] ECODE_TLBR = 6'h3F,
  parameter int         CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_wb_ex,
  input  logic             i_ertn_flush,
  input  logic [5:0]       i_wb_ecode,
  input  logic [31:0]      i_csr_eentry,
  input  logic [31:0]      i_csr_tlbrentry,
  input  logic [31:0]      i_csr_era,
  input  logic             i_has_int,
  input  logic             i_fetch_ready,
  output logic             o_flush_all,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic             o_ctrl_busy,
  output logic             o_int_req,
  output logic [CNT_W-1:0] o_exc_cnt,
  output logic [CNT_W-1:0] o_ertn_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIR} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_redirect_pc;
  logic              r_int_req;
  logic [CNT_W-1:0]  r_exc_cnt;
  logic [CNT_W-1:0]  r_ertn_cnt;
  logic              w_accept;
  logic              w_acc_exc;
  logic              w_acc_ertn;
  logic [31:0]       w_target;

  // Events outside IDLE come from already-flushed upstream and are dropped.
  assign w_accept   = (r_state == S_IDLE) & (i_wb_ex | i_ertn_flush);
  assign w_acc_exc  = w_accept & i_wb_ex;
  assign w_acc_ertn = w_accept & ~i_wb_ex & i_ertn_flush;

  always_comb begin
    w_target = i_csr_era;
    if (i_wb_ex) begin
      w_target = (i_wb_ecode == ECODE_TLBR) ? i_csr_tlbrentry : i_csr_eentry;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    o_flush_all      = 1'b0;
    o_redirect_valid = 1'b0;
    o_ctrl_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_ctrl_busy = 1'b0;
        if (w_accept) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        o_flush_all = 1'b1;
        w_state_nxt = S_REDIR;
      end
      S_REDIR: begin
        o_redirect_valid = 1'b1;
        if (i_fetch_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_redirect_pc <= 32'h0;
      r_int_req     <= 1'b0;
      r_exc_cnt     <= '0;
      r_ertn_cnt    <= '0;
    end else begin
      if (w_accept) r_redirect_pc <= w_target;
      r_int_req <= i_has_int & (r_state == S_IDLE) & ~i_wb_ex & ~i_ertn_flush;
      if (w_acc_exc && !(&r_exc_cnt))   r_exc_cnt  <= r_exc_cnt + CNT_ONE;
      if (w_acc_ertn && !(&r_ertn_cnt)) r_ertn_cnt <= r_ertn_cnt + CNT_ONE;
    end
  end

  assign o_redirect_pc = r_redirect_pc;
  assign o_int_req     = r_int_req;
  assign o_exc_cnt     = r_exc_cnt;
  assign o_ertn_cnt    = r_ertn_cnt;

endmodule
